// File: rtl/perf_counter_bank_if.sv
// MEM-stage access bus into the perf counter window: request from the core, zero-latency
// response back from the counter bank.
interface perf_counter_bank_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] wdata;
  logic        hit;
  logic        resp;
  logic [15:0] rdata;

  modport master (
    output mem_address, mem_read, mem_write, wdata,
    input  hit, resp, rdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write, wdata,
    output hit, resp, rdata
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of event counters with shared 32-bit read shadow, freeze and sticky overflow.
// Define PERF_CNT_SATURATE_EN to make counters hold at all-ones on overflow instead of wrapping.
module perf_counter_bank #(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] inc,
  perf_counter_bank_if.slave bus
);

  localparam logic [15:0] CtrlOff = 16'(4 * NUM_CH);
  localparam logic [15:0] StatOff = 16'(4 * NUM_CH + 2);
  localparam logic [15:0] WinEnd  = 16'(4 * NUM_CH + 4);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic                 freeze_q, freeze_d;
  logic [15:0]          shadow_q, shadow_d;

  logic [15:0]       offset, off_w;
  logic              chan_hit, ctrl_hit, stat_hit, lo_sel;
  logic              rd_hit, wr_hit, clr_all;
  logic [NUM_CH-1:0] sel;
  logic              unused_bits;

  // Bit 0 of the byte offset is ignored; the unsigned compare also rejects addresses below base.
  assign offset   = bus.mem_address - BASE_ADDR;
  assign off_w    = {offset[15:1], 1'b0};
  assign bus.hit  = off_w < WinEnd;
  assign chan_hit = off_w < CtrlOff;
  assign ctrl_hit = off_w == CtrlOff;
  assign stat_hit = off_w == StatOff;
  assign lo_sel   = ~off_w[1];
  assign rd_hit   = bus.hit & bus.mem_read;
  assign wr_hit   = bus.hit & bus.mem_write;
  assign bus.resp = bus.hit & (bus.mem_read | bus.mem_write);
  assign clr_all  = wr_hit & ctrl_hit & bus.wdata[1];

  assign unused_bits = ^{offset[0], bus.wdata};

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sel[k] = chan_hit && (off_w[5:2] == 4'(k));
    end
  end

  // Read path and shadow latch.
  always_comb begin
    logic [31:0] ext;
    bus.rdata = '0;
    shadow_d  = shadow_q;
    for (int k = 0; k < NUM_CH; k++) begin
      ext = 32'(cnt_q[k]);
      if (sel[k]) begin
        bus.rdata = lo_sel ? ext[15:0] : shadow_q;
        if (rd_hit && lo_sel) shadow_d = ext[31:16];
      end
    end
    if (ctrl_hit)  bus.rdata = {15'd0, freeze_q};
    if (stat_hit)  bus.rdata = 16'(ovf_q);
    if (!rd_hit || rst) bus.rdata = '0;
  end

  // Counter, overflow and freeze next state; clears win over increments.
  always_comb begin
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    freeze_d = freeze_q;
    if (wr_hit && ctrl_hit) freeze_d = bus.wdata[0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (inc[k] && !freeze_q) begin
        if (&cnt_q[k]) begin
          ovf_d[k] = 1'b1;
`ifdef PERF_CNT_SATURATE_EN
          cnt_d[k] = cnt_q[k];
`else
          cnt_d[k] = '0;
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end
      if (wr_hit && stat_hit && bus.wdata[k]) ovf_d[k] = 1'b0;
      if (clr_all || (wr_hit && sel[k] && lo_sel)) begin
        cnt_d[k] = '0;
        ovf_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '{default: '0};
      ovf_q    <= '0;
      freeze_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      freeze_q <= freeze_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench: wide instance (4 ch x 20 bit) for decode/shadow/freeze, narrow instance
// (4 ch x 4 bit) to reach overflow quickly.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] inc_a = '0;
  logic [3:0] inc_b = '0;
  int         n_tests = 0;
  int         n_fail = 0;

  perf_counter_bank_if bus_a ();
  perf_counter_bank_if bus_b ();

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(20), .BASE_ADDR(16'hFF00)) dut_a (
    .clk (clk),
    .rst (rst),
    .inc (inc_a),
    .bus (bus_a)
  );

  perf_counter_bank #(.NUM_CH(4), .CNT_WIDTH(4), .BASE_ADDR(16'hFF00)) dut_b (
    .clk (clk),
    .rst (rst),
    .inc (inc_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] addr;
    logic        exp_hit;
    logic        exp_resp;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit b, input logic [15:0] a, input logic r, input logic w,
                       input logic [15:0] d);
    if (b) begin
      bus_b.mem_address = a; bus_b.mem_read = r; bus_b.mem_write = w; bus_b.wdata = d;
    end else begin
      bus_a.mem_address = a; bus_a.mem_read = r; bus_a.mem_write = w; bus_a.wdata = d;
    end
  endtask

  function automatic logic [17:0] sample(input bit b);
    return b ? {bus_b.hit, bus_b.resp, bus_b.rdata} : {bus_a.hit, bus_a.resp, bus_a.rdata};
  endfunction

  task automatic idle(input bit b);
    drive(b, 16'h0000, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic rd_chk(input bit b, input logic [15:0] a, input logic [15:0] exp,
                        input string name);
    logic [17:0] s;
    drive(b, a, 1'b1, 1'b0, 16'h0000);
    #2;
    s = sample(b);
    check(name, {14'd0, s}, {14'd0, 2'b11, exp});
    @(posedge clk); #1;
    idle(b);
  endtask

  task automatic wr(input bit b, input logic [15:0] a, input logic [15:0] d);
    drive(b, a, 1'b0, 1'b1, d);
    @(posedge clk); #1;
    idle(b);
  endtask

  task automatic pulse(input bit b, input logic [3:0] mask, input int n);
    if (b) inc_b = mask; else inc_a = mask;
    repeat (n) @(posedge clk);
    #1;
    if (b) inc_b = '0; else inc_a = '0;
  endtask

  initial begin
    logic [17:0] s;
    for (int i = 0; i < 10; i++) vecs[i] = '{16'(16'hFF00 + 2 * i), 1'b1, 1'b1, 16'h0000};
    vecs[10] = '{16'h1000, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{16'hFF14, 1'b0, 1'b0, 16'h0000};
    vecs[12] = '{16'hFEFE, 1'b0, 1'b0, 16'h0000};

    idle(1'b0);
    idle(1'b1);
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Post-reset window decode and read-back.
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, vecs[i].addr, 1'b1, 1'b0, 16'h0000);
      #2;
      s = sample(1'b0);
      check($sformatf("reset_vec_%0h", vecs[i].addr), {14'd0, s},
            {14'd0, vecs[i].exp_hit, vecs[i].exp_resp, vecs[i].exp_rdata});
      @(posedge clk); #1;
      idle(1'b0);
    end

    pulse(1'b0, 4'b0010, 5);
    rd_chk(1'b0, 16'hFF04, 16'h0005, "ch1_count5");
    rd_chk(1'b0, 16'hFF00, 16'h0000, "ch0_untouched");

    // Crossing 16 bits: low word read latches the high half into the shadow.
    pulse(1'b0, 4'b0100, 65539);
    rd_chk(1'b0, 16'hFF08, 16'h0003, "ch2_low_65539");
    pulse(1'b0, 4'b0100, 4);
    rd_chk(1'b0, 16'hFF0A, 16'h0001, "ch2_shadow_high");
    rd_chk(1'b0, 16'hFF12, 16'h0000, "status_no_ovf");

    // Clear beats increment in the same cycle.
    pulse(1'b0, 4'b0001, 7);
    rd_chk(1'b0, 16'hFF00, 16'h0007, "ch0_count7");
    inc_a = 4'b0001;
    drive(1'b0, 16'hFF00, 1'b0, 1'b1, 16'h0000);
    @(posedge clk); #1;
    inc_a = '0;
    idle(1'b0);
    rd_chk(1'b0, 16'hFF00, 16'h0000, "clear_beats_inc");

    // Freeze, then clear-all.
    wr(1'b0, 16'hFF10, 16'h0001);
    pulse(1'b0, 4'b1111, 3);
    rd_chk(1'b0, 16'hFF00, 16'h0000, "frozen_ch0");
    rd_chk(1'b0, 16'hFF04, 16'h0005, "frozen_ch1");
    rd_chk(1'b0, 16'hFF08, 16'h0007, "frozen_ch2");
    rd_chk(1'b0, 16'hFF0C, 16'h0000, "frozen_ch3");
    rd_chk(1'b0, 16'hFF10, 16'h0001, "ctrl_freeze");
    wr(1'b0, 16'hFF10, 16'h0002);
    rd_chk(1'b0, 16'hFF04, 16'h0000, "clrall_ch1");
    rd_chk(1'b0, 16'hFF08, 16'h0000, "clrall_ch2");
    rd_chk(1'b0, 16'hFF10, 16'h0000, "clrall_ctrl");
    rd_chk(1'b0, 16'hFF12, 16'h0000, "clrall_status");
    pulse(1'b0, 4'b0010, 2);
    rd_chk(1'b0, 16'hFF04, 16'h0002, "unfrozen_count");

    // Read and write together: old value returned, write applied.
    drive(1'b0, 16'hFF04, 1'b1, 1'b1, 16'h0000);
    #2;
    s = sample(1'b0);
    check("rw_same_cycle", {14'd0, s}, {14'd0, 2'b11, 16'h0002});
    @(posedge clk); #1;
    idle(1'b0);
    rd_chk(1'b0, 16'hFF04, 16'h0000, "rw_write_applied");

    // Narrow instance: overflow at 4 bits.
    pulse(1'b1, 4'b1000, 16);
`ifdef PERF_CNT_SATURATE_EN
    rd_chk(1'b1, 16'hFF0C, 16'h000F, "ovf_sat_low");
`else
    rd_chk(1'b1, 16'hFF0C, 16'h0000, "ovf_wrap_low");
`endif
    rd_chk(1'b1, 16'hFF0E, 16'h0000, "narrow_high_zero");
    rd_chk(1'b1, 16'hFF12, 16'h0008, "ovf_status");
    pulse(1'b1, 4'b0001, 3);
    rd_chk(1'b1, 16'hFF00, 16'h0003, "narrow_ch0");
    rd_chk(1'b1, 16'hFF12, 16'h0008, "ovf_sticky");
    wr(1'b1, 16'hFF12, 16'h0008);
    rd_chk(1'b1, 16'hFF12, 16'h0000, "ovf_w1c");
    rd_chk(1'b1, 16'hFF0C, 16'h0000 | (16'hF & {16{1'b0}}) |
`ifdef PERF_CNT_SATURATE_EN
           16'h000F,
`else
           16'h0000,
`endif
           "ovf_w1c_keeps_count");

    // Asynchronous reset during a hit read.
    pulse(1'b0, 4'b0010, 3);
    drive(1'b0, 16'hFF04, 1'b1, 1'b0, 16'h0000);
    #2;
    s = sample(1'b0);
    check("pre_rst_read", {16'd0, s[15:0]}, 32'h0000_0003);
    rst = 1'b1;
    #1;
    s = sample(1'b0);
    check("rdata_in_rst", {16'd0, s[15:0]}, 32'h0000_0000);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    idle(1'b0);
    rd_chk(1'b0, 16'hFF04, 16'h0000, "post_rst_ch1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised, memory-mapped bank of hardware event counters. It sits beside the MEM stage of the pipelined LC-3b core, in the place of the fixed six-counter hit/miss logic. Each channel counts single-cycle event pulses from the caches and pipeline. Software reads, clears, freezes and checks overflow through ordinary LDR/STR accesses to a reserved address window, which the block claims so that the data-memory Wishbone cycle is suppressed.

## Interface
Parameters:
- NUM_CH, 8, number of counter channels (1..16)
- CNT_WIDTH, 16, counter width in bits (1..32)
- BASE_ADDR, 16'hFF00, byte address of the window; must be 4-byte aligned

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- inc  input  NUM_CH  per-channel event pulse; counts +1 per cycle high
- mem_address  input  16  MEM-stage byte address
- mem_read  input  1  MEM-stage load request
- mem_write  input  1  MEM-stage store request
- wdata  input  16  store data
- hit  output  1  mem_address is inside the window (combinational)
- resp  output  1  hit & (mem_read | mem_write) (combinational)
- rdata  output  16  read data (combinational); 0 when the access is not a hit read

## Operation
- Address decoding uses offset = mem_address − BASE_ADDR. Bit 0 is ignored. The window spans offsets 0 .. 4*NUM_CH+3.
  - offset 4k: channel k low word, cnt[k][15:0]
  - offset 4k+2: channel k high word, taken from the shadow register (zero-extended)
  - offset 4*NUM_CH: control word; bit0 = freeze, other bits read 0
  - offset 4*NUM_CH+2: status word; ovf[NUM_CH-1:0], zero-extended
- Counting: when inc[k] & !freeze, cnt[k] increments by 1.
  - When cnt[k] is all-ones, the increment sets sticky ovf[k]. The next value then depends on the Configuration macro.
- Atomic 32-bit read: any hit read of a low word latches shadow <= cnt[k] >> 16, using the pre-increment value of that cycle.
  - There is one shared shadow register.
  - A low-word read held for several cycles relatches on every cycle.
- Writes:
  - A write to a low word clears cnt[k] and ovf[k].
  - A write to a high word is ignored.
  - A write to the control word sets freeze = wdata[0]. If wdata[1] = 1, all counters and all ovf bits clear.
  - A write to the status word is write-1-to-clear on ovf.
- Priority in one cycle: clear (per-channel or clear-all) > increment. A channel cleared in the same cycle it is incremented ends at 0.
- If mem_read and mem_write are both asserted, the write takes effect and rdata still returns the pre-edge value.
- Reset values: all cnt 0, shadow 0, freeze 0, ovf 0. Outputs follow combinationally: hit/resp from the inputs, rdata 0 unless there is a hit read.

## Timing
- Read latency is zero. rdata and resp are valid in the same cycle as the request, so they can be muxed directly onto the MEM-stage response.
- Write effects, increments and shadow latch all occur at the next rising clk edge.
- An increment in cycle N is visible to a read in cycle N+1.
- A held write (pipeline stall) reapplies every cycle. This is idempotent.
- Asserting rst mid-access clears all state immediately. While rst is high, rdata of a hit read returns 0.
- CNT_WIDTH ≤ 16: high words and the shadow read 0.

## Configuration
- PERF_CNT_SATURATE_EN
  - Defined: on overflow, a counter holds at all-ones. ovf is set.
  - Undefined (default): on overflow, a counter wraps to 0. ovf is set.

## Test plan
Bench configuration: NUM_CH=4, CNT_WIDTH=20, BASE_ADDR=16'hFF00. Window addresses are ch k low word FF00+4k, ctrl FF10, status FF12.

- Reset, then read each of FF00..FF12 → resp=1, rdata=0. Read 16'h1000 → hit=0, resp=0, rdata=0.
- inc[1] high for 5 cycles, then read FF04 → 16'h0005. FF00 → 16'h0000.
- inc[2] high for 65539 cycles, then stop. Read FF08 → 16'h0003. Pulse inc[2] 4 more times, then read FF0A → 16'h0001 (shadow value, not the live count).
- Count ch0 to 7. In one cycle, drive a write to FF00 and inc[0] together → next-cycle read of FF00 returns 0.
- Write FF10=16'h0001, pulse inc[0..3] → all counters unchanged, ctrl reads 16'h0001. Then write FF10=16'h0002 → all counters and ovf 0, freeze 0.
- Overflow case: inc[3] high for 2^20 cycles.
  - Macro undefined: FF0C reads 0, status reads 16'h0008.
  - Macro defined: FF0C reads FFFF and FF0E reads 000F.
  - Then write FF12=16'h0008 → status reads 0.
